uart_tx_fifo: RTL and testbench

//   Transmit-side byte buffer that sits directly upstream of the UART block.
//   The host pushes bytes at its own rate. The FIFO presents them to the UART

---
 rtl/uart_tx_fifo.sv | 85 ++++++++
 tb/tb_uart_tx_fifo.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Transmit-side first-word fall-through FIFO feeding the UART Tx_valid/ready handshake.
// Each entry stores {err_flag, data}. full and almost_full are registered.
module uart_tx_fifo #(
    parameter int unsigned WIDTH_SIZE = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned AF_LEVEL   = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [WIDTH_SIZE-1:0]    wr_data,
    input  logic                     wr_err,
    input  logic                     flush,
    output logic                     full,
    output logic                     almost_full,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     ovf_clr,
    output logic                     Tx_valid,
    output logic [WIDTH_SIZE-1:0]    input_tx,
    output logic                     Tx_err,
    input  logic                     ready
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH_SIZE:0] r_mem [DEPTH];
    logic [AW-1:0]       r_wptr;
    logic [AW-1:0]       r_rptr;
    logic [CW-1:0]       r_count;
    logic                r_full;
    logic                r_af;
    logic                r_ovf;

    logic                w_push;
    logic                w_pop;
    logic [CW-1:0]       w_count_next;

    // A push while full is dropped even if the same edge pops.
    assign w_push       = wr_en & ~r_full;
    assign w_pop        = (r_count != '0) & ready;
    assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

    always_ff @(posedge clk) begin
        if (!reset || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_full  <= 1'b0;
            r_af    <= 1'b0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            if (w_pop)  r_rptr <= r_rptr + AW'(1);
            r_count <= w_count_next;
            r_full  <= (w_count_next == CW'(DEPTH));
            r_af    <= (w_count_next >= CW'(AF_LEVEL));
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (wr_en && r_full && !flush) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    // Storage is intentionally not reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (reset && !flush && w_push) begin
            r_mem[r_wptr] <= {wr_err, wr_data};
        end
    end

    assign Tx_valid            = (r_count != '0);
    assign {Tx_err, input_tx}  = r_mem[r_rptr];
    assign full                = r_full;
    assign almost_full         = r_af;
    assign count               = r_count;
    assign overflow            = r_ovf;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted pushes are queued, pops are compared in order.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       wr_err;
    logic       flush;
    logic       ovf_clr;
    logic       ready;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       tx_valid;
    logic [7:0] input_tx;
    logic       tx_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic [8:0] sb_q[$];

    always #5 clk = ~clk;

    uart_tx_fifo #(
        .WIDTH_SIZE (8),
        .DEPTH      (16),
        .AF_LEVEL   (12)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .wr_err      (wr_err),
        .flush       (flush),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .Tx_valid    (tx_valid),
        .input_tx    (input_tx),
        .Tx_err      (tx_err),
        .ready       (ready)
    );

    // One clock: sample mid-cycle, update scoreboard, return 1ns after the edge.
    task automatic tick(output logic popped, output logic [8:0] act,
                        output logic exp_ok, output logic [8:0] exp);
        logic was_full;
        #4;
        popped   = reset && !flush && tx_valid && ready;
        act      = {tx_err, input_tx};
        exp_ok   = 1'b0;
        exp      = '0;
        was_full = (sb_q.size() >= 16);
        if (!reset || flush) begin
            sb_q.delete();
        end else begin
            if (popped && sb_q.size() > 0) begin
                exp    = sb_q.pop_front();
                exp_ok = 1'b1;
            end
            if (wr_en && !was_full) sb_q.push_back({wr_err, wr_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 0; wr_data = '0; wr_err = 0; flush = 0; ovf_clr = 0; ready = 0;
    endtask

    task automatic test_reset();
        logic p, eo; logic [8:0] a, e;
        idle_inputs();
        reset = 0;
        tick(p, a, eo, e);
        reset = 1;
        n_checks++;
        if (count !== 5'd0 || tx_valid !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0
            || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: count=%0d valid=%b full=%b af=%b ovf=%b required 0/0/0/0/0",
                     count, tx_valid, full, almost_full, overflow);
        end
    endtask

    task automatic test_single_hold();
        logic p, eo; logic [8:0] a, e;
        wr_en = 1; wr_data = 8'hA5; wr_err = 0; ready = 0;
        tick(p, a, eo, e);
        wr_en = 0;
        n_checks++;
        if (tx_valid !== 1'b1 || input_tx !== 8'hA5 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL single_push: valid=%b data=%h count=%0d required 1/a5/1",
                     tx_valid, input_tx, count);
        end
        for (int i = 0; i < 10; i++) begin
            tick(p, a, eo, e);
            n_checks++;
            if (tx_valid !== 1'b1 || input_tx !== 8'hA5 || tx_err !== 1'b0) begin
                n_fail++;
                $display("FAIL hold[%0d]: valid=%b data=%h err=%b required 1/a5/0",
                         i, tx_valid, input_tx, tx_err);
            end
        end
        ready = 1;
        tick(p, a, eo, e);
        ready = 0;
        n_checks++;
        if (!p || !eo || a !== e || tx_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL single_pop: popped=%b got=%h exp=%h valid=%b count=%0d",
                     p, a, e, tx_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        logic p, eo; logic [8:0] a, e;
        logic [7:0] pat [3];
        int n_pop = 0;
        pat[0] = 8'hA5; pat[1] = 8'hAB; pat[2] = 8'h3C;
        ready = 1;
        for (int t = 0; t < 8; t++) begin
            wr_en   = (t < 3);
            wr_data = (t < 3) ? pat[t] : 8'h00;
            tick(p, a, eo, e);
            if (p) begin
                n_checks++;
                if (!eo || a !== e || a[7:0] !== pat[n_pop] || t != n_pop + 1) begin
                    n_fail++;
                    $display("FAIL b2b_pop[%0d]: got=%h required=%h at tick %0d (want %0d)",
                             n_pop, a, pat[n_pop], t, n_pop + 1);
                end
                n_pop++;
            end
        end
        wr_en = 0; ready = 0;
        n_checks++;
        if (n_pop != 3 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_total: pops=%0d valid=%b required 3/0", n_pop, tx_valid);
        end
    endtask

    task automatic drain(input string name, input int expected);
        logic p, eo; logic [8:0] a, e;
        int n_pop = 0;
        ready = 1;
        for (int t = 0; t < expected + 4; t++) begin
            tick(p, a, eo, e);
            if (p) begin
                n_checks++;
                if (!eo || a !== e) begin
                    n_fail++;
                    $display("FAIL %s_pop[%0d]: got=%h required=%h", name, n_pop, a, e);
                end
                n_pop++;
            end
        end
        ready = 0;
        n_checks++;
        if (n_pop != expected || tx_valid !== 1'b0 || count !== 5'd0) begin
            n_fail++;
            $display("FAIL %s_drain: pops=%0d count=%0d required %0d/0", name, n_pop, count,
                     expected);
        end
    endtask

    task automatic test_fill_overflow();
        logic p, eo; logic [8:0] a, e;
        ready = 0;
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_data = 8'(i);
            tick(p, a, eo, e);
            n_checks++;
            if (count !== 5'(i + 1) || full !== (i == 15) || almost_full !== (i + 1 >= 12)) begin
                n_fail++;
                $display("FAIL fill[%0d]: count=%0d full=%b af=%b required %0d/%b/%b", i, count,
                         full, almost_full, i + 1, i == 15, i + 1 >= 12);
            end
        end
        wr_data = 8'hFF;
        tick(p, a, eo, e);
        wr_en = 0;
        n_checks++;
        if (overflow !== 1'b1 || count !== 5'd16 || full !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_push: ovf=%b count=%0d full=%b required 1/16/1", overflow, count,
                     full);
        end
        drain("fill", 16);
    endtask

    task automatic test_full_push_pop();
        logic p, eo; logic [8:0] a, e;
        ovf_clr = 1;
        tick(p, a, eo, e);
        ovf_clr = 0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_preclear: ovf=%b required 0", overflow);
        end
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_data = 8'h40 + 8'(i);
            tick(p, a, eo, e);
        end
        wr_data = 8'hEE; ready = 1;
        tick(p, a, eo, e);
        wr_en = 0; ready = 0;
        n_checks++;
        if (!p || !eo || a !== e || count !== 5'd15 || overflow !== 1'b1 || full !== 1'b0) begin
            n_fail++;
            $display("FAIL full_pushpop: got=%h exp=%h count=%0d ovf=%b full=%b required 15/1/0",
                     a, e, count, overflow, full);
        end
        ovf_clr = 1;
        tick(p, a, eo, e);
        ovf_clr = 0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clr: ovf=%b required 0", overflow);
        end
        drain("fullpp", 15);
    endtask

    task automatic test_err_flag();
        logic p, eo; logic [8:0] a, e;
        ready = 0;
        wr_en = 1; wr_data = 8'h11; wr_err = 0; tick(p, a, eo, e);
        wr_data = 8'h5A; wr_err = 1; tick(p, a, eo, e);
        wr_data = 8'h22; wr_err = 0; tick(p, a, eo, e);
        wr_en = 0;
        n_checks++;
        if (tx_err !== 1'b0 || input_tx !== 8'h11) begin
            n_fail++;
            $display("FAIL err_head0: data=%h err=%b required 11/0", input_tx, tx_err);
        end
        ready = 1; tick(p, a, eo, e); ready = 0;
        n_checks++;
        if (tx_err !== 1'b1 || input_tx !== 8'h5A) begin
            n_fail++;
            $display("FAIL err_head1: data=%h err=%b required 5a/1", input_tx, tx_err);
        end
        drain("err", 2);
    endtask

    task automatic test_clear(input logic use_flush);
        logic p, eo; logic [8:0] a, e;
        ready = 0;
        for (int i = 0; i < 5; i++) begin
            wr_en = 1; wr_data = 8'h90 + 8'(i);
            tick(p, a, eo, e);
        end
        wr_en = 0; ready = 1;
        tick(p, a, eo, e);
        wr_en = 1; wr_data = 8'hCC;
        if (use_flush) flush = 1;
        else reset = 0;
        tick(p, a, eo, e);
        flush = 0; reset = 1; wr_en = 0; ready = 0;
        n_checks++;
        if (count !== 5'd0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear(flush=%b): count=%0d valid=%b required 0/0", use_flush, count,
                     tx_valid);
        end
        wr_en = 1; wr_data = 8'h77;
        tick(p, a, eo, e);
        wr_en = 0;
        n_checks++;
        if (tx_valid !== 1'b1 || input_tx !== 8'h77 || count !== 5'd1) begin
            n_fail++;
            $display("FAIL after_clear(flush=%b): valid=%b data=%h count=%0d required 1/77/1",
                     use_flush, tx_valid, input_tx, count);
        end
        drain("clear", 1);
    endtask

    initial begin
        test_reset();
        test_single_hold();
        test_back_to_back();
        test_fill_overflow();
        test_full_push_pop();
        test_err_flag();
        test_clear(1'b1);
        test_clear(1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
